fifo_buffer_sync: RTL and testbench

// - Single-clock synchronous FIFO: 4-bit words by default, 8 entries deep.
// - Buffers data between a producer and a consumer in the same clock domain.
// - Provides EMPTY/FULL status flags and a registered read-data output.
// - Has a global enable (EN) that freezes all state when low.

---
 rtl/fifo_buffer_pkg.sv | 20 ++
 rtl/fifo_buffer_mem.sv | 31 +++
 rtl/fifo_buffer_sync.sv | 74 +++++++
 tb/tb_fifo_buffer_sync.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/fifo_buffer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_buffer_pkg : default sizes and pointer-width helper for the FIFO |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
package fifo_buffer_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int DEPTH_DEF  = 8;

  // Ceiling log2, floored at 1 so a pointer is never zero bits wide.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage : fifo_buffer_pkg
`default_nettype wire

// File: rtl/fifo_buffer_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_buffer_mem : DEPTH x DATA_W register file, sync write, comb read |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module fifo_buffer_mem
  import fifo_buffer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int PTR_W  = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule : fifo_buffer_mem
`default_nettype wire

// File: rtl/fifo_buffer_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_buffer_sync : single-clock FIFO with enable and registered read  |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module fifo_buffer_sync
  import fifo_buffer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              EN,
  input  logic              WR,
  input  logic              RD,
  input  logic [DATA_W-1:0] dataIn,
  output logic [DATA_W-1:0] dataOut,
  output logic              EMPTY,
  output logic              FULL
);

  localparam int PTR_W = clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic [DATA_W-1:0] rdata;
  logic              wr_ok;
  logic              rd_ok;

  // Flags decode straight from the count register, so they are glitch-free.
  assign EMPTY = (count == '0);
  assign FULL  = (count == CNT_FULL);

  assign wr_ok = EN & WR & ~FULL;
  assign rd_ok = EN & RD & ~EMPTY;

  fifo_buffer_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk   (Clk),
    .we    (wr_ok),
    .waddr (wr_ptr),
    .wdata (dataIn),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      dataOut <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) begin
        rd_ptr  <= rd_ptr + 1'b1;
        dataOut <= rdata;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule : fifo_buffer_sync
`default_nettype wire

// File: tb/tb_fifo_buffer_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fifo_buffer_sync : directed self-checking bench for the FIFO       |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_fifo_buffer_sync;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       EN;
  logic       WR;
  logic       RD;
  logic [3:0] dataIn;
  logic [3:0] dataOut;
  logic       EMPTY;
  logic       FULL;

  int checks = 0;
  int errors = 0;

  fifo_buffer_sync dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .EN      (EN),
    .WR      (WR),
    .RD      (RD),
    .dataIn  (dataIn),
    .dataOut (dataOut),
    .EMPTY   (EMPTY),
    .FULL    (FULL)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, take the edge, sample 1 time unit later.
  task automatic op(input logic wr, input logic rd, input logic [3:0] d);
    WR = wr;
    RD = rd;
    dataIn = d;
    @(posedge Clk);
    #1;
    WR = 1'b0;
    RD = 1'b0;
  endtask

  initial begin
    logic [3:0] alt_vals [5];
    logic [3:0] tail_vals [8];
    alt_vals  = '{4'h0, 4'h1, 4'h2, 4'h3, 4'hF};
    tail_vals = '{4'hC, 4'hD, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};

    // Reset held two edges while a write is requested
    Rst = 1'b0; EN = 1'b1; WR = 1'b1; RD = 1'b0; dataIn = 4'h5;
    @(posedge Clk); #1;
    op(1'b1, 1'b0, 4'h5);
    check("rst_empty", {3'b0, EMPTY}, 4'h1);
    check("rst_full", {3'b0, FULL}, 4'h0);
    check("rst_dout", dataOut, 4'h0);
    Rst = 1'b1;
    op(1'b0, 1'b0, 4'h0);
    check("rst_nowrite_empty", {3'b0, EMPTY}, 4'h1);

    // Alternating single write / single read
    for (int i = 0; i < 5; i++) begin
      op(1'b1, 1'b0, alt_vals[i]);
      check("alt_wr_empty", {3'b0, EMPTY}, 4'h0);
      op(1'b0, 1'b1, 4'h0);
      check("alt_rd_dout", dataOut, alt_vals[i]);
      check("alt_rd_empty", {3'b0, EMPTY}, 4'h1);
    end

    // Fill to full, overflow attempt, drain in order
    for (int i = 1; i <= 8; i++) begin
      op(1'b1, 1'b0, 4'(i));
      if (i == 7) check("fill7_full", {3'b0, FULL}, 4'h0);
    end
    check("fill8_full", {3'b0, FULL}, 4'h1);
    op(1'b1, 1'b0, 4'h9);
    check("ovf_full", {3'b0, FULL}, 4'h1);
    for (int i = 1; i <= 8; i++) begin
      op(1'b0, 1'b1, 4'h0);
      check("drain_dout", dataOut, 4'(i));
    end
    check("drain_empty", {3'b0, EMPTY}, 4'h1);
    op(1'b0, 1'b1, 4'h0);
    check("udf_dout", dataOut, 4'h8);
    check("udf_empty", {3'b0, EMPTY}, 4'h1);

    // Simultaneous read+write while empty: write only, no bypass
    op(1'b1, 1'b1, 4'hA);
    check("rw_empty_dout", dataOut, 4'h8);
    check("rw_empty_empty", {3'b0, EMPTY}, 4'h0);

    // Three entries A,B,C; simultaneous op keeps three and returns A
    op(1'b1, 1'b0, 4'hB);
    op(1'b1, 1'b0, 4'hC);
    op(1'b1, 1'b1, 4'hD);
    check("rw_mid_dout", dataOut, 4'hA);
    check("rw_mid_empty", {3'b0, EMPTY}, 4'h0);
    check("rw_mid_full", {3'b0, FULL}, 4'h0);

    // Contents B,C,D; add 1..5 to reach full
    for (int i = 1; i <= 5; i++) op(1'b1, 1'b0, 4'(i));
    check("refill_full", {3'b0, FULL}, 4'h1);
    op(1'b1, 1'b1, 4'hE);
    check("rw_full_dout", dataOut, 4'hB);
    check("rw_full_full", {3'b0, FULL}, 4'h0);
    op(1'b1, 1'b0, 4'h6);
    check("refull_full", {3'b0, FULL}, 4'h1);

    // Disabled for four cycles with both requests high
    EN = 1'b0;
    for (int i = 0; i < 4; i++) begin
      op(1'b1, 1'b1, 4'hF);
      check("dis_full", {3'b0, FULL}, 4'h1);
      check("dis_empty", {3'b0, EMPTY}, 4'h0);
      check("dis_dout", dataOut, 4'hB);
    end
    EN = 1'b1;
    for (int i = 0; i < 8; i++) begin
      op(1'b0, 1'b1, 4'h0);
      check("resume_dout", dataOut, tail_vals[i]);
    end
    check("resume_empty", {3'b0, EMPTY}, 4'h1);

    // Reset in the middle of a fill
    for (int i = 7; i <= 11; i++) op(1'b1, 1'b0, 4'(i));
    check("midfill_empty", {3'b0, EMPTY}, 4'h0);
    Rst = 1'b0;
    op(1'b1, 1'b1, 4'h9);
    Rst = 1'b1;
    check("midrst_empty", {3'b0, EMPTY}, 4'h1);
    check("midrst_full", {3'b0, FULL}, 4'h0);
    check("midrst_dout", dataOut, 4'h0);
    op(1'b1, 1'b0, 4'h3);
    check("post_wr_empty", {3'b0, EMPTY}, 4'h0);
    op(1'b0, 1'b1, 4'h0);
    check("post_rd_dout", dataOut, 4'h3);
    check("post_rd_empty", {3'b0, EMPTY}, 4'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fifo_buffer_sync
`default_nettype wire
